// File: rtl/mem_port_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arb_pkg
//   Shared definitions for the IF/EX memory port arbiter.
//   - owner_e           : which requester owns the read data returning next cycle
//   - MEM_ARB_STREAK_W  : width of the EX-streak counter (limit may be 1..15)
// -----------------------------------------------------------------------------
package mem_port_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_EX   = 2'b10
  } owner_e;

  localparam int MEM_ARB_STREAK_W = 4;

endpackage : mem_port_arb_pkg

// File: rtl/mem_port_arb_rsp_track.sv
// -----------------------------------------------------------------------------
// mem_arb_rsp_track
//   Remembers who was granted a read in the previous cycle and steers the
//   one-cycle-latency memory read data to that owner.
//
//   Ports
//     clk, rst        clock, synchronous active-high reset
//     if_gnt_i        IF granted this cycle (always a read)
//     ex_rd_gnt_i     EX granted this cycle with a load (stores return nothing)
//     mem_rdata_i     memory read data for the previous cycle's read
//     if_rvalid_o     IF read data valid
//     if_rdata_o      IF read data (0 when not valid)
//     ex_rvalid_o     EX load data valid
//     ex_rdata_o      EX load data (0 when not valid)
// -----------------------------------------------------------------------------
module mem_arb_rsp_track
  import mem_port_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_gnt_i,
  input  logic              ex_rd_gnt_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              ex_rvalid_o,
  output logic [DATA_W-1:0] ex_rdata_o
);

  owner_e rsp_owner_q, rsp_owner_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    rsp_owner_d = OWN_NONE;
    if (if_gnt_i) begin
      rsp_owner_d = OWN_IF;
    end else if (ex_rd_gnt_i) begin
      rsp_owner_d = OWN_EX;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_owner_q <= OWN_NONE;
    end else begin
      rsp_owner_q <= rsp_owner_d;
    end
  end

  // During reset the owner register still holds the pre-reset value for the
  // first cycle; gating with rst drops the read that was in flight when reset
  // rose, together with whatever the memory returns in that cycle.
  always_comb begin
    if_rvalid_o = ~rst & (rsp_owner_q == OWN_IF);
    ex_rvalid_o = ~rst & (rsp_owner_q == OWN_EX);
    if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
    ex_rdata_o  = ex_rvalid_o ? mem_rdata_i : '0;
  end

endmodule : mem_arb_rsp_track

// File: rtl/mem_port_arb.sv
// -----------------------------------------------------------------------------
// mem_port_arb
//   Shares one single-port synchronous memory between instruction fetch (IF)
//   and the execute-stage load/store port (EX). One grant per cycle, decided
//   combinationally. EX normally wins; after MAX_EX_STREAK consecutive EX
//   grants while IF was waiting, IF wins once. Read data (1-cycle latency) is
//   routed back to the owner of the read. hold_flag_o stalls the pipeline
//   whenever a requester is denied.
//
//   Parameters
//     ADDR_W, DATA_W   address / data width
//     MAX_EX_STREAK    EX grants allowed in a row while IF waits (1..15)
//
//   Ports
//     clk, rst                     clock, synchronous active-high reset
//     if_req_i/if_addr_i           fetch request (read only)
//     if_gnt_o                     fetch granted this cycle
//     if_rvalid_o/if_rdata_o       fetch read response
//     ex_req_i/ex_we_i/ex_addr_i/
//     ex_wdata_i/ex_wmask_i        load/store request
//     ex_gnt_o                     EX granted this cycle
//     ex_rvalid_o/ex_rdata_o       load response
//     mem_req_o/mem_we_o/
//     mem_addr_o/mem_wdata_o/
//     mem_wmask_o                  memory strobe and command (all 0 when idle)
//     mem_rdata_i                  memory read data, one cycle after the strobe
//     hold_flag_o                  stall request toward ctrl
// -----------------------------------------------------------------------------
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_EX_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DATA_W-1:0]   if_rdata_o,

  input  logic                ex_req_i,
  input  logic                ex_we_i,
  input  logic [ADDR_W-1:0]   ex_addr_i,
  input  logic [DATA_W-1:0]   ex_wdata_i,
  input  logic [DATA_W/8-1:0] ex_wmask_i,
  output logic                ex_gnt_o,
  output logic                ex_rvalid_o,
  output logic [DATA_W-1:0]   ex_rdata_o,

  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,

  output logic                hold_flag_o
);

  localparam logic [MEM_ARB_STREAK_W-1:0] STREAK_MAX =
    MEM_ARB_STREAK_W'(MAX_EX_STREAK);

  // Consecutive EX grants taken while IF was also requesting.
  logic [MEM_ARB_STREAK_W-1:0] streak_q, streak_d;
  logic                        ex_rd_gnt;

  // ---------------------------------------------------------------------------
  // Grant selection: EX has priority until it has starved IF for STREAK_MAX
  // cycles in a row. Nothing is granted while in reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    if_gnt_o = 1'b0;
    ex_gnt_o = 1'b0;
    if (!rst) begin
      if (if_req_i && ex_req_i) begin
        if (streak_q == STREAK_MAX) begin
          if_gnt_o = 1'b1;
        end else begin
          ex_gnt_o = 1'b1;
        end
      end else if (ex_req_i) begin
        ex_gnt_o = 1'b1;
      end else if (if_req_i) begin
        if_gnt_o = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Streak counter: counts only while IF is actually waiting, so an idle IF or
  // an IF grant restarts the window. Saturates at the limit.
  // ---------------------------------------------------------------------------
  always_comb begin
    streak_d = streak_q;
    if (if_gnt_o || !if_req_i) begin
      streak_d = '0;
    end else if (ex_gnt_o && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory port: command comes from the granted requester; everything is
  // driven to 0 when there is no grant so the macro sees a quiet bus.
  // IF only reads, so it supplies no write data or byte mask.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    if (ex_gnt_o) begin
      mem_req_o   = 1'b1;
      mem_we_o    = ex_we_i;
      mem_addr_o  = ex_addr_i;
      mem_wdata_o = ex_wdata_i;
      mem_wmask_o = ex_wmask_i;
    end else if (if_gnt_o) begin
      mem_req_o  = 1'b1;
      mem_addr_o = if_addr_i;
    end
  end

  // Any requester left waiting stalls the pipeline; stores blocked by the
  // streak limit are covered by the same term.
  assign hold_flag_o = ~rst & ((if_req_i & ~if_gnt_o) | (ex_req_i & ~ex_gnt_o));

  // Stores complete at grant and have no response.
  assign ex_rd_gnt = ex_gnt_o & ~ex_we_i;

  mem_arb_rsp_track #(
    .DATA_W (DATA_W)
  ) u_rsp_track (
    .clk         (clk),
    .rst         (rst),
    .if_gnt_i    (if_gnt_o),
    .ex_rd_gnt_i (ex_rd_gnt),
    .mem_rdata_i (mem_rdata_i),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .ex_rvalid_o (ex_rvalid_o),
    .ex_rdata_o  (ex_rdata_o)
  );

endmodule : mem_port_arb

// File: tb/tb_mem_port_arb.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arb
//   Self-checking bench for mem_port_arb (default parameters). A behavioural
//   model tracks how long IF has been starved and who owns the next read
//   response; every cycle all DUT outputs are compared against it at the
//   falling clock edge. Directed scenarios add explicit expectations on top.
// -----------------------------------------------------------------------------
module tb_mem_port_arb;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MAXS   = 4;

  logic              clk;
  logic              rst;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              ex_req_i;
  logic              ex_we_i;
  logic [ADDR_W-1:0] ex_addr_i;
  logic [DATA_W-1:0] ex_wdata_i;
  logic [3:0]        ex_wmask_i;
  logic              ex_gnt_o;
  logic              ex_rvalid_o;
  logic [DATA_W-1:0] ex_rdata_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [3:0]        mem_wmask_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              hold_flag_o;

  mem_port_arb #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .MAX_EX_STREAK (MAXS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .ex_req_i    (ex_req_i),
    .ex_we_i     (ex_we_i),
    .ex_addr_i   (ex_addr_i),
    .ex_wdata_i  (ex_wdata_i),
    .ex_wmask_i  (ex_wmask_i),
    .ex_gnt_o    (ex_gnt_o),
    .ex_rvalid_o (ex_rvalid_o),
    .ex_rdata_o  (ex_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_wmask_o (mem_wmask_o),
    .mem_rdata_i (mem_rdata_i),
    .hold_flag_o (hold_flag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  //   ex_wins_in_row : EX grants taken back to back while IF kept waiting
  //   next_owner     : 0 = nobody, 1 = IF, 2 = EX gets the memory data next cycle
  // ---------------------------------------------------------------------------
  int ex_wins_in_row = 0;
  int next_owner     = 0;

  task automatic model_check();
    bit             e_if, e_ex, e_hold, e_ifv, e_exv;
    logic [31:0]    e_addr, e_wdata;
    logic [3:0]     e_mask;
    bit             e_we;

    // Response side: whoever read last cycle sees the data, unless in reset.
    e_ifv = (rst == 1'b0) && (next_owner == 1);
    e_exv = (rst == 1'b0) && (next_owner == 2);

    // Grant side: EX is preferred unless IF has already waited MAXS EX grants.
    e_if = 0;
    e_ex = 0;
    if (!rst) begin
      if (ex_req_i && (!if_req_i || ex_wins_in_row < MAXS)) e_ex = 1;
      else if (if_req_i)                                    e_if = 1;
    end
    e_hold = (if_req_i && !e_if) || (ex_req_i && !e_ex);
    if (rst) e_hold = 0;

    e_we = 0; e_addr = 0; e_wdata = 0; e_mask = 0;
    if (e_ex) begin
      e_we = ex_we_i; e_addr = ex_addr_i; e_wdata = ex_wdata_i; e_mask = ex_wmask_i;
    end else if (e_if) begin
      e_addr = if_addr_i;
    end

    check("if_gnt",    if_gnt_o,    e_if);
    check("ex_gnt",    ex_gnt_o,    e_ex);
    check("hold",      hold_flag_o, e_hold);
    check("mem_req",   mem_req_o,   e_if | e_ex);
    check("mem_we",    mem_we_o,    e_we);
    check("mem_addr",  mem_addr_o,  e_addr);
    check("mem_wdata", mem_wdata_o, e_wdata);
    check("mem_wmask", mem_wmask_o, e_mask);
    check("if_rvalid", if_rvalid_o, e_ifv);
    check("if_rdata",  if_rdata_o,  e_ifv ? mem_rdata_i : 32'h0);
    check("ex_rvalid", ex_rvalid_o, e_exv);
    check("ex_rdata",  ex_rdata_o,  e_exv ? mem_rdata_i : 32'h0);

    // Advance to the state after the coming clock edge.
    if (rst) begin
      ex_wins_in_row = 0;
      next_owner     = 0;
    end else begin
      if (e_if)                next_owner = 1;
      else if (e_ex && !e_we)  next_owner = 2;
      else                     next_owner = 0;
      if (e_ex && if_req_i) ex_wins_in_row = (ex_wins_in_row + 1 > MAXS) ? MAXS : ex_wins_in_row + 1;
      else                  ex_wins_in_row = 0;
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the
  // falling edge (4 units later).
  task automatic drive(input logic r, input logic ir, input logic [31:0] ia,
                       input logic er, input logic ew, input logic [31:0] ea,
                       input logic [31:0] ed, input logic [3:0] em, input logic [31:0] rd);
    rst = r; if_req_i = ir; if_addr_i = ia;
    ex_req_i = er; ex_we_i = ew; ex_addr_i = ea; ex_wdata_i = ed; ex_wmask_i = em;
    mem_rdata_i = rd;
    #4;
  endtask

  task automatic tick();
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 32'hBAD0_0000 + i);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; if_req_i = 0; if_addr_i = 0; ex_req_i = 0; ex_we_i = 0;
    ex_addr_i = 0; ex_wdata_i = 0; ex_wmask_i = 0; mem_rdata_i = 0;
    @(posedge clk); #1;

    // ---- Reset state, even with both requesting and data on the bus ----
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 32'h40, 1, 1, 32'h80, 32'h1234, 4'hF, 32'h77);
      check("rst_if_gnt", if_gnt_o, 1'b0);
      check("rst_mem_req", mem_req_o, 1'b0);
      check("rst_hold", hold_flag_o, 1'b0);
      tick();
    end
    idle(1);

    // ---- IF-only reads 0x100, 0x104 ----
    drive(0, 1, 32'h100, 0, 0, 0, 0, 0, 32'h0);
    check("ifrd_gnt0", if_gnt_o, 1'b1);
    check("ifrd_hold0", hold_flag_o, 1'b0);
    tick();
    drive(0, 1, 32'h104, 0, 0, 0, 0, 0, 32'hAAAA0001);
    check("ifrd_gnt1", if_gnt_o, 1'b1);
    check("ifrd_rdata1", if_rdata_o, 32'hAAAA0001);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'hAAAA0002);
    check("ifrd_rvalid2", if_rvalid_o, 1'b1);
    check("ifrd_rdata2", if_rdata_o, 32'hAAAA0002);
    tick();
    idle(1);

    // ---- EX store ----
    drive(0, 0, 0, 1, 1, 32'h2000, 32'hDEADBEEF, 4'b0011, 32'h0);
    check("st_we", mem_we_o, 1'b1);
    check("st_mask", mem_wmask_o, 4'b0011);
    check("st_wdata", mem_wdata_o, 32'hDEADBEEF);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h9999);
    check("st_no_rvalid", ex_rvalid_o, 1'b0);
    tick();
    idle(1);

    // ---- Streak limit: both request for 9 cycles, EX issuing stores ----
    for (int c = 0; c < 9; c++) begin
      drive(0, 1, 32'h300 + 4 * c, 1, 1, 32'h4000 + c, 32'hC0DE0000 + c, 4'hF, 32'h5000 + c);
      check($sformatf("streak_ex_c%0d", c), ex_gnt_o, (c != 4));
      check($sformatf("streak_if_c%0d", c), if_gnt_o, (c == 4));
      check($sformatf("streak_hold_c%0d", c), hold_flag_o, 1'b1);
      if (c == 4) check("streak_store_held", mem_we_o, 1'b0);
      tick();
    end
    idle(2);

    // ---- Interleaved IF read then EX load ----
    drive(0, 1, 32'h500, 0, 0, 0, 0, 0, 32'h0);
    tick();
    drive(0, 0, 0, 1, 0, 32'h600, 0, 4'hF, 32'h11);
    check("il_if_data", if_rdata_o, 32'h11);
    check("il_ex_quiet", ex_rvalid_o, 1'b0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h22);
    check("il_ex_data", ex_rdata_o, 32'h22);
    check("il_if_quiet", if_rvalid_o, 1'b0);
    tick();

    // ---- Reset mid-operation after building up an EX streak ----
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 32'h700, 1, 0, 32'h800, 0, 4'hF, 32'h0);
      tick();
    end
    drive(0, 1, 32'h900, 0, 0, 0, 0, 0, 32'h0);  // IF read granted
    check("mid_if_gnt", if_gnt_o, 1'b1);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h55);       // reset rises with data 0x55
    check("mid_rst_rvalid", if_rvalid_o, 1'b0);
    check("mid_rst_rdata", if_rdata_o, 32'h0);
    tick();
    drive(0, 1, 32'hA00, 0, 0, 0, 0, 0, 32'h0);
    check("post_rst_if_gnt", if_gnt_o, 1'b1);
    tick();
    // Streak starts from zero again: EX gets MAXS grants before IF.
    for (int c = 0; c <= MAXS; c++) begin
      drive(0, 1, 32'hB00, 1, 0, 32'hC00, 0, 4'hF, 32'h0);
      check($sformatf("post_rst_streak_c%0d", c), if_gnt_o, (c == MAXS));
      tick();
    end
    idle(1);

    // ---- Random traffic ----
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) != 0), $urandom,
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom,
            $urandom, 4'($urandom), $urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mem_port_arb
